// File: rtl/pattern_detector.sv
// Serial pattern detector: matches a reloadable N-bit pattern (MSB oldest)
// on a one-bit input stream, with overlapping/non-overlapping modes, a
// sample-enable qualifier and a saturating match counter.
//
// Ports:
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   en           sample qualifier; a is consumed only when en=1
//   a            serial data bit
//   overlap      1 = suffix bits reused after a match, 0 = restart history
//   load         single-cycle pattern load strobe (discards history)
//   pattern_in   new pattern, captured when load=1
//   clear_count  synchronous clear of match_count (wins over a hit)
//   y            registered one-cycle match pulse
//   match_count  saturating number of matches since reset/clear
module pattern_detector #(
  parameter int unsigned    N       = 4,
  parameter logic [N-1:0]   PATTERN = N'(4'b1101),
  parameter int unsigned    CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             a,
  input  logic             overlap,
  input  logic             load,
  input  logic [N-1:0]     pattern_in,
  input  logic             clear_count,
  output logic             y,
  output logic [CNT_W-1:0] match_count
);

  localparam int unsigned        FILL_W   = $clog2(N);
  localparam logic [FILL_W-1:0]  FILL_MAX = FILL_W'(N - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX  = '1;

  // Reject pattern lengths outside the supported range at elaboration.
  if (N < 2 || N > 32) begin : g_bad_n
    $error("pattern_detector: N must be in 2..32");
  end

  logic [N-1:0]      pat;
  logic [N-2:0]      hist;
  logic [FILL_W-1:0] fill;
  logic [N-1:0]      window_c;
  logic              hit_c;

  // Candidate window: stored history with the current bit appended as LSB.
  assign window_c = {hist, a};

  // A match needs a full history, a consumed sample and no load this edge.
  assign hit_c = en & ~load & (fill == FILL_MAX) & (window_c == pat);

  // Pattern register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pat <= PATTERN;
    end else if (load) begin
      pat <= pattern_in;
    end
  end

  // History shift register and valid-bit fill counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist <= '0;
      fill <= '0;
    end else if (load) begin
      hist <= '0;
      fill <= '0;
    end else if (en) begin
      // Taking the low N-1 bits of the window keeps this legal for N=2.
      hist <= window_c[N-2:0];
      if (hit_c && !overlap) begin
        fill <= '0;
      end else if (fill != FILL_MAX) begin
        fill <= fill + FILL_W'(1);
      end
    end
  end

  // Registered match pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      y <= 1'b0;
    end else begin
      y <= hit_c;
    end
  end

  // Saturating match counter; clear has priority over a hit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      match_count <= '0;
    end else if (clear_count) begin
      match_count <= '0;
    end else if (hit_c && (match_count != CNT_MAX)) begin
      match_count <= match_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pattern_detector.sv
// Self-checking bench for pattern_detector: directed scenarios followed by
// randomized traffic, checked against a queue-based reference model. Two
// instances share the stimulus: one with an 8-bit counter, one with 2 bits.
module tb_pattern_detector;

  localparam int unsigned N = 4;

  logic       clk;
  logic       reset_n;
  logic       en;
  logic       a;
  logic       overlap;
  logic       load;
  logic [3:0] pattern_in;
  logic       clear_count;
  logic       y;
  logic [7:0] cnt8;
  logic       y_sat;
  logic [1:0] cnt2;

  pattern_detector u_dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .en          (en),
    .a           (a),
    .overlap     (overlap),
    .load        (load),
    .pattern_in  (pattern_in),
    .clear_count (clear_count),
    .y           (y),
    .match_count (cnt8)
  );

  pattern_detector #(.CNT_W(2)) u_sat (
    .clk         (clk),
    .reset_n     (reset_n),
    .en          (en),
    .a           (a),
    .overlap     (overlap),
    .load        (load),
    .pattern_in  (pattern_in),
    .clear_count (clear_count),
    .y           (y_sat),
    .match_count (cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: bits consumed since the last restart, oldest first.
  logic [3:0] m_pat;
  bit         q[$];
  int         m_cnt8;
  int         m_cnt2;
  int         checks;
  int         errors;
  logic       yv;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pat  = 4'b1101;
    q.delete();
    m_cnt8 = 0;
    m_cnt2 = 0;
  endtask

  function automatic bit tail_matches();
    for (int i = 0; i < N; i++) begin
      if (q[i] != m_pat[N-1-i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Apply one clock of stimulus, advance the model, then check both DUTs.
  task automatic step(input logic e, input logic d, input logic ov, input logic ld,
                      input logic [3:0] pin, input logic clr);
    logic exp_hit;
    en = e; a = d; overlap = ov; load = ld; pattern_in = pin; clear_count = clr;
    exp_hit = 1'b0;
    if (ld) begin
      m_pat = pin;
      q.delete();
    end else if (e) begin
      q.push_back(d);
      if (q.size() > N) q.delete(0);
      exp_hit = (q.size() == N) && tail_matches();
      if (exp_hit && !ov) q.delete();
    end
    if (clr) begin
      m_cnt8 = 0;
      m_cnt2 = 0;
    end else if (exp_hit) begin
      if (m_cnt8 < 255) m_cnt8++;
      if (m_cnt2 < 3)   m_cnt2++;
    end
    @(posedge clk);
    #1;
    yv = y;
    chk("y", 32'(y), 32'(exp_hit));
    chk("y_sat", 32'(y_sat), 32'(exp_hit));
    chk("count8", 32'(cnt8), 32'(m_cnt8));
    chk("count2", 32'(cnt2), 32'(m_cnt2));
  endtask

  initial begin
    logic [6:0] s;
    logic [6:0] ys;
    logic [6:0] e3;
    logic [6:0] d3;
    logic [4:0] ys5;
    checks = 0;
    errors = 0;
    reset_n = 1'b0;
    en = 1'b0; a = 1'b0; overlap = 1'b0; load = 1'b0;
    pattern_in = 4'b0000; clear_count = 1'b0;
    model_reset();
    #12;
    chk("reset_y", 32'(y), 32'd0);
    chk("reset_count8", 32'(cnt8), 32'd0);
    chk("reset_count2", 32'(cnt2), 32'd0);
    reset_n = 1'b1;

    // Overlapping: 1101101 matches twice.
    step(1'b0, 1'b0, 1'b1, 1'b1, 4'b1101, 1'b1);
    s = 7'b1101101;
    ys = '0;
    for (int i = 6; i >= 0; i--) begin
      step(1'b1, s[i], 1'b1, 1'b0, 4'b0000, 1'b0);
      ys = {ys[5:0], yv};
    end
    chk("ovl_pulses", 32'(ys), 32'(7'b0001001));
    chk("ovl_count", 32'(cnt8), 32'd2);

    // Non-overlapping: same stream matches once.
    step(1'b0, 1'b0, 1'b0, 1'b1, 4'b1101, 1'b1);
    ys = '0;
    for (int i = 6; i >= 0; i--) begin
      step(1'b1, s[i], 1'b0, 1'b0, 4'b0000, 1'b0);
      ys = {ys[5:0], yv};
    end
    chk("novl_pulses", 32'(ys), 32'(7'b0001000));
    chk("novl_count", 32'(cnt8), 32'd1);

    // Gated samples are ignored.
    step(1'b0, 1'b0, 1'b1, 1'b1, 4'b1101, 1'b1);
    e3 = 7'b1100011;
    d3 = 7'b1101001;
    ys = '0;
    for (int i = 6; i >= 0; i--) begin
      step(e3[i], d3[i], 1'b1, 1'b0, 4'b0000, 1'b0);
      ys = {ys[5:0], yv};
    end
    chk("gate_pulses", 32'(ys), 32'(7'b0000001));

    // Load mid-stream discards history; all-zeros fires on every bit once primed.
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 4'b0000, 1'b0);
    chk("load_y", 32'(y), 32'd0);
    ys5 = '0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
      ys5 = {ys5[3:0], yv};
    end
    chk("zeros_pulses", 32'(ys5), 32'(5'b00011));
    chk("zeros_count", 32'(cnt8), 32'd2);

    // Saturation of the 2-bit counter, then clear beats a hit.
    step(1'b0, 1'b0, 1'b1, 1'b1, 4'b1111, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);
    chk("sat_count2", 32'(cnt2), 32'd3);
    chk("sat_count8", 32'(cnt8), 32'd5);
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b1);
    chk("clr_hit_y", 32'(y), 32'd1);
    chk("clr_hit_count", 32'(cnt2), 32'd0);

    // Asynchronous reset mid-stream; pattern returns to 1101.
    step(1'b0, 1'b0, 1'b1, 1'b1, 4'b0110, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    chk("areset_y", 32'(y), 32'd0);
    chk("areset_count8", 32'(cnt8), 32'd0);
    chk("areset_count2", 32'(cnt2), 32'd0);
    #2 reset_n = 1'b1;
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);
    chk("post_reset_single", 32'(y), 32'd0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);
    chk("post_reset_match", 32'(y), 32'd1);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      step(1'(($urandom % 8) != 0), 1'($urandom), 1'($urandom),
           1'(($urandom % 40) == 0), 4'($urandom), 1'(($urandom % 60) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pattern_detector.md
# pattern_detector

Parametrised Moore serial pattern detector that matches an N-bit pattern on a one-bit input stream. The pattern is reloadable at run time. The block supports overlapping and non-overlapping match modes, a sample-enable qualifier and a saturating match counter. It sits after a bit-serial front end and replaces fixed hard-coded FSM detectors: one instance covers any pattern of length 2..32.

## Interface
- N, 4: pattern length in bits; legal range 2..32.
- PATTERN, 4'b1101: reset value of the pattern register, N bits; the MSB is matched first (oldest bit).
- CNT_W, 8: width of the match counter.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- en  input  1  sample qualifier; `a` is consumed only on edges where en=1.
- a  input  1  serial data bit.
- overlap  input  1  1 = overlapping matches allowed; 0 = history restarts after each match.
- load  input  1  single-cycle pattern load strobe.
- pattern_in  input  N  new pattern, captured when load=1.
- clear_count  input  1  synchronous clear of match_count.
- y  output  1  registered match pulse (Moore).
- match_count  output  CNT_W  number of matches since reset/clear; saturates at all-ones.

## Operation
- State:
  - pattern register `pat` (N bits).
  - history shift register `hist` (N-1 bits, newest bit at the LSB).
  - fill counter `fill` (0..N-1): number of valid history bits.
  - `y` register.
  - `match_count` register.
- Reset (reset_n=0, asynchronous):
  - pat=PATTERN, hist=0, fill=0.
  - y=0, match_count=0.
- Match condition, combinational:
  - hit = en & ~load & (fill == N-1) & ({hist, a} == pat).
- Each rising edge, in priority order:
  - load=1: pat<=pattern_in, hist<=0, fill<=0, y<=0. The `a` bit on that edge is discarded.
  - Otherwise, if en=1:
    - hist<={hist[N-3:0], a}; fill<=min(fill+1, N-1).
    - If hit and overlap=0: fill<=0. Only bits after the match count toward the next match.
    - If hit and overlap=1: fill stays at N-1. Suffix bits are reused.
  - en=0 and load=0: hist and fill hold.
  - y<=hit on every edge. y is high for exactly one cycle per match, and low when en=0.
- Match counter:
  - clear_count=1: match_count<=0. Clear wins over a simultaneous hit.
  - Else, if hit and match_count != all-ones: match_count<=match_count+1.
  - At all-ones the counter holds; no wrap.
- overlap is sampled on the edge where hit occurs. Changing it mid-stream affects only the next match decision.
- A pattern of all-ones or all-zeros in overlap mode fires on every enabled bit once primed.

## Timing
- Latency: the completing bit is sampled on edge k; y=1 from edge k until edge k+1. match_count updates on the same edge k.
- The first match is possible on the N-th enabled sample after reset, load, or a non-overlap match.
- Back-to-back hits produce y high on consecutive cycles, with no forced gap.
- A load arriving mid-stream takes effect on that edge. The next match needs N fresh enabled bits after the load edge.
- An asynchronous reset mid-stream clears everything immediately. Deassertion is sampled at the next edge.
- Outputs never depend combinationally on the inputs.

## Test plan
- Default 1101, overlap=1, en=1, stream 1,1,0,1,1,0,1 -> y pulses after bits 4 and 7; match_count=2.
- Same stream, overlap=0 -> y pulses after bit 4 only; match_count=1.
- Stream 1,1,en=0 for 3 cycles (a toggling),0,1 with en=1 -> gated cycles ignored; y pulses once, after the final bit.
- load pattern_in=4'b0000 after stream 1,1,0; then 0,0,0,0,0 (overlap=1) -> prior history discarded; pulses after 4th and 5th zeros; count=2.
- CNT_W=2, all-ones pattern, overlap=1, 8 ones -> count reaches 3 and holds. Assert clear_count together with a hit -> count=0.
- Assert reset_n=0 asynchronously mid-stream after 1,1,0 -> y=0, count=0 immediately. After release, 1 alone gives no match; 1,1,0,1 matches.
